// File: rtl/tow_game_if.sv
// Tug-of-war controller bus: player/prescaler inputs and display-side outputs.
// master drives the inputs (board logic / bench), slave is the controller.
interface tow_game_if #(
  parameter int POS_MAX = 8,
  parameter int POS_W   = 4,
  parameter int CNT_W   = 2
);
  logic             tick;
  logic             btn_l;
  logic             btn_r;
  logic             start;
  logic [POS_W-1:0] pos;
  logic [POS_MAX:0] led;
  logic [CNT_W-1:0] count;
  logic             playing;
  logic             win_l;
  logic             win_r;

  modport master (
    output tick, btn_l, btn_r, start,
    input  pos, led, count, playing, win_l, win_r
  );

  modport slave (
    input  tick, btn_l, btn_r, start,
    output pos, led, count, playing, win_l, win_r
  );
endinterface

// File: rtl/tow_game_ctrl.sv
// Tug-of-war round sequencer: IDLE -> COUNTDOWN -> PLAY -> WIN.
// Button presses are edge-detected, latched as pending until the next tick,
// and resolved into a one-step rope move (ties cancel).
// Optional macro FALSE_START_EN: a press during the countdown is a false start
// and hands the round to the other player (both at once returns to IDLE).
module tow_game_ctrl #(
  parameter int POS_MAX     = 8,
  parameter int POS_W       = 4,
  parameter int START_TICKS = 3,
  parameter int CNT_W       = 2
) (
  input  logic           clk,
  input  logic           rst,
  tow_game_if.slave      bus
);

  localparam logic [POS_W-1:0] CENTRE    = POS_W'(POS_MAX / 2);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(POS_MAX);
  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_TICKS);

  typedef enum logic [1:0] {IDLE, COUNTDOWN, PLAY, WIN} state_t;

  state_t           state;
  logic [POS_W-1:0] pos_q, pos_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             playing_q, win_l_q, win_r_q;
  logic             pend_l, pend_r, prev_l, prev_r;
  logic             press_l, press_r, eff_l, eff_r;
  logic             fs_l, fs_r;

  assign press_l = bus.btn_l & ~prev_l;
  assign press_r = bus.btn_r & ~prev_r;
  // a press landing on the tick cycle still counts toward that tick
  assign eff_l   = pend_l | press_l;
  assign eff_r   = pend_r | press_r;

`ifdef FALSE_START_EN
  assign fs_l = press_l;
  assign fs_r = press_r;
`else
  assign fs_l = 1'b0;
  assign fs_r = 1'b0;
`endif

  // candidate position for this tick; bounds are caught before any overshoot
  always_comb begin
    pos_nxt = pos_q;
    if (eff_l & ~eff_r)      pos_nxt = pos_q - 1'b1;
    else if (eff_r & ~eff_l) pos_nxt = pos_q + 1'b1;
  end

  // round FSM with registered outputs, pending flags and button edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pos_q     <= CENTRE;
      cnt_q     <= '0;
      playing_q <= 1'b0;
      win_l_q   <= 1'b0;
      win_r_q   <= 1'b0;
      pend_l    <= 1'b0;
      pend_r    <= 1'b0;
      prev_l    <= 1'b0;
      prev_r    <= 1'b0;
    end else begin
      prev_l <= bus.btn_l;
      prev_r <= bus.btn_r;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= COUNTDOWN;
            cnt_q <= START_CNT;
          end
        end
        COUNTDOWN: begin
          if (fs_l | fs_r) begin
            cnt_q <= '0;
            if (fs_l & fs_r) begin
              state <= IDLE;
            end else begin
              state   <= WIN;
              win_l_q <= fs_r;
              win_r_q <= fs_l;
              pos_q   <= fs_l ? POS_LAST : '0;
            end
          end else if (bus.tick) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              state     <= PLAY;
              playing_q <= 1'b1;
            end
          end
        end
        PLAY: begin
          if (bus.tick) begin
            pend_l <= 1'b0;
            pend_r <= 1'b0;
            pos_q  <= pos_nxt;
            if (pos_nxt == '0) begin
              state     <= WIN;
              playing_q <= 1'b0;
              win_l_q   <= 1'b1;
            end else if (pos_nxt == POS_LAST) begin
              state     <= WIN;
              playing_q <= 1'b0;
              win_r_q   <= 1'b1;
            end
          end else begin
            pend_l <= eff_l;
            pend_r <= eff_r;
          end
        end
        WIN: begin
          if (bus.start) begin
            state   <= COUNTDOWN;
            cnt_q   <= START_CNT;
            pos_q   <= CENTRE;
            win_l_q <= 1'b0;
            win_r_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pos     = pos_q;
  assign bus.led     = (POS_MAX+1)'(1) << pos_q;
  assign bus.count   = cnt_q;
  assign bus.playing = playing_q;
  assign bus.win_l   = win_l_q;
  assign bus.win_r   = win_r_q;

endmodule

// File: tb/tb_tow_game_ctrl.sv
// Bench for tow_game_ctrl: directed vector table, corner-case sequences,
// then random stimulus checked against a round-level reference model.
module tb_tow_game_ctrl;
  localparam int POS_MAX = 8;
  localparam int POS_W   = 4;
  localparam int START   = 3;
  localparam int CNT_W   = 2;
  localparam int C       = POS_MAX / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tow_game_if #(.POS_MAX(POS_MAX), .POS_W(POS_W), .CNT_W(CNT_W)) bus ();

  tow_game_ctrl #(.POS_MAX(POS_MAX), .POS_W(POS_W), .START_TICKS(START), .CNT_W(CNT_W))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
  endtask

  task automatic chk_all(input string name, input int p, input int c, input int pl,
                         input int wl, input int wr);
    chk({name, ".pos"}, int'(bus.pos), p);
    chk({name, ".led"}, int'(bus.led), 1 << p);
    chk({name, ".count"}, int'(bus.count), c);
    chk({name, ".playing"}, int'(bus.playing), pl);
    chk({name, ".win_l"}, int'(bus.win_l), wl);
    chk({name, ".win_r"}, int'(bus.win_r), wr);
  endtask

  // inputs change 1 time unit after the edge; outputs sampled at the same point
  task automatic step(input bit tk, input bit bl, input bit br, input bit st);
    bus.tick = tk; bus.btn_l = bl; bus.btn_r = br; bus.start = st;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit tk, bl, br, st;
    int p, c, pl, wl, wr;
  } vec_t;
  vec_t tbl [26];

  // reference model: round phase, rope position as plain integer arithmetic
  localparam int PH_IDLE = 0, PH_CD = 1, PH_PLAY = 2, PH_WIN = 3;
  int m_ph, m_pos, m_cnt, m_wl, m_wr;
  bit m_pl, m_pr, m_prevl, m_prevr;

  task automatic model_reset();
    m_ph = PH_IDLE; m_pos = C; m_cnt = 0; m_wl = 0; m_wr = 0;
    m_pl = 0; m_pr = 0; m_prevl = 0; m_prevr = 0;
  endtask

  task automatic model_step(input bit tk, input bit bl, input bit br, input bit st);
    bit pl, pr, el, er, fsl, fsr;
    pl = bl && !m_prevl;
    pr = br && !m_prevr;
    m_prevl = bl; m_prevr = br;
`ifdef FALSE_START_EN
    fsl = pl; fsr = pr;
`else
    fsl = 0; fsr = 0;
`endif
    case (m_ph)
      PH_IDLE: if (st) begin m_ph = PH_CD; m_cnt = START; end
      PH_CD: begin
        if (fsl && fsr) begin m_ph = PH_IDLE; m_cnt = 0; end
        else if (fsl) begin m_ph = PH_WIN; m_wr = 1; m_pos = POS_MAX; m_cnt = 0; end
        else if (fsr) begin m_ph = PH_WIN; m_wl = 1; m_pos = 0; m_cnt = 0; end
        else if (tk) begin
          m_cnt--;
          if (m_cnt == 0) m_ph = PH_PLAY;
        end
      end
      PH_PLAY: begin
        el = m_pl || pl;
        er = m_pr || pr;
        if (tk) begin
          m_pos += int'(er) - int'(el);
          m_pl = 0; m_pr = 0;
          if (m_pos == 0) begin m_ph = PH_WIN; m_wl = 1; end
          else if (m_pos == POS_MAX) begin m_ph = PH_WIN; m_wr = 1; end
        end else begin
          m_pl = el; m_pr = er;
        end
      end
      default: if (st) begin
        m_ph = PH_CD; m_cnt = START; m_pos = C; m_wl = 0; m_wr = 0;
      end
    endcase
  endtask

  initial begin
    //         tk bl br st  pos cnt pl wl wr
    tbl[0]  = '{0, 0, 0, 1,  4, 3, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0,  4, 2, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0,  4, 1, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0,  4, 1, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 0,  4, 0, 1, 0, 0};
    tbl[5]  = '{0, 0, 1, 0,  4, 0, 1, 0, 0};
    tbl[6]  = '{1, 0, 1, 0,  5, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 0,  5, 0, 1, 0, 0};
    tbl[8]  = '{0, 0, 1, 0,  5, 0, 1, 0, 0};
    tbl[9]  = '{1, 0, 0, 0,  6, 0, 1, 0, 0};
    tbl[10] = '{0, 1, 1, 0,  6, 0, 1, 0, 0};
    tbl[11] = '{1, 0, 0, 0,  6, 0, 1, 0, 0};
    tbl[12] = '{1, 1, 0, 0,  5, 0, 1, 0, 0};
    tbl[13] = '{1, 1, 0, 0,  5, 0, 1, 0, 0};
    tbl[14] = '{1, 0, 0, 0,  5, 0, 1, 0, 0};
    tbl[15] = '{1, 0, 1, 0,  6, 0, 1, 0, 0};
    tbl[16] = '{0, 0, 0, 0,  6, 0, 1, 0, 0};
    tbl[17] = '{1, 0, 1, 0,  7, 0, 1, 0, 0};
    tbl[18] = '{0, 0, 0, 0,  7, 0, 1, 0, 0};
    tbl[19] = '{1, 0, 1, 0,  8, 0, 0, 0, 1};
    tbl[20] = '{1, 0, 0, 0,  8, 0, 0, 0, 1};
    tbl[21] = '{1, 1, 1, 0,  8, 0, 0, 0, 1};
    tbl[22] = '{0, 0, 0, 1,  4, 3, 0, 0, 0};
    tbl[23] = '{1, 0, 0, 1,  4, 2, 0, 0, 0};
    tbl[24] = '{1, 0, 0, 0,  4, 1, 0, 0, 0};
    tbl[25] = '{1, 0, 0, 0,  4, 0, 1, 0, 0};

    bus.tick = 0; bus.btn_l = 0; bus.btn_r = 0; bus.start = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_all("reset", C, 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      step(tbl[i].tk, tbl[i].bl, tbl[i].br, tbl[i].st);
      chk_all($sformatf("vec%0d", i), tbl[i].p, tbl[i].c, tbl[i].pl, tbl[i].wl, tbl[i].wr);
    end

    // reset while playing at pos 6
    step(1, 0, 1, 0); step(0, 0, 0, 0);
    step(1, 0, 1, 0); step(0, 0, 0, 0);
    chk_all("pre_rst", 6, 0, 1, 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 0);
    chk_all("mid_rst", C, 0, 0, 0, 0);
    rst = 1'b0;

    // left player walks the rope home; last press coincides with the tick
    step(0, 0, 0, 1);
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    chk_all("play_entry", 4, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin step(1, 1, 0, 0); step(0, 0, 0, 0); end
    chk_all("at_pos1", 1, 0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk_all("win_l", 0, 0, 0, 1, 0);
    step(0, 0, 0, 0); step(1, 1, 0, 0); step(1, 0, 1, 0);
    chk_all("win_l_hold", 0, 0, 0, 1, 0);
    step(0, 0, 0, 1);
    chk_all("restart", 4, 3, 0, 0, 0);
    step(1, 0, 0, 0);
    chk_all("cd2", 4, 2, 0, 0, 0);
    step(0, 1, 0, 0);
`ifdef FALSE_START_EN
    chk_all("false_start_l", 8, 0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk_all("fs_restart", 4, 3, 0, 0, 0);
    step(0, 1, 1, 0);
    chk_all("false_start_both", 4, 0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk_all("fs_idle_start", 4, 3, 0, 0, 0);
`else
    chk_all("cd_press_ignored", 4, 2, 0, 0, 0);
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    chk_all("play_after_press", 4, 0, 1, 0, 0);
`endif

    // random stimulus against the reference model
    rst = 1'b1;
    step(0, 0, 0, 0);
    model_reset();
    rst = 1'b0;
    begin
      bit bl, br;
      bl = 0; br = 0;
      for (int n = 0; n < 4000; n++) begin
        bit tk, st, rs;
        tk = ($urandom_range(3) == 0);
        st = ($urandom_range(15) == 0);
        rs = ($urandom_range(999) == 0);
        if ($urandom_range(2) == 0) bl = ~bl;
        if ($urandom_range(2) == 0) br = ~br;
        rst = rs;
        step(tk, bl, br, st);
        if (rs) model_reset();
        else model_step(tk, bl, br, st);
        chk_all($sformatf("rnd%0d", n), m_pos, m_cnt, int'(m_ph == PH_PLAY), m_wl, m_wr);
      end
      rst = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/tow_game_ctrl.md
Name: tow_game_ctrl

Overview:
- Tug-of-war game controller. Sequences one round: idle, countdown, play, win.
- Consumes the single-cycle slow enable `tick` from the divide-by-256 prescaler. Arbitrates the two players' button presses into rope-position moves.
- Drives the position register, the one-hot LED bar and the winner flags seen by the display logic.

Parameters:
- POS_MAX, 8, last rope position. Positions run 0..POS_MAX; centre is POS_MAX/2 (must be even, ≥ 2).
- POS_W, 4, width of `pos`; must satisfy 2^POS_W > POS_MAX.
- START_TICKS, 3, number of ticks in the countdown phase (≥ 1).
- CNT_W, 2, width of `count`; must hold START_TICKS.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  slow enable, one clk cycle wide.
- btn_l  in  1  left player button, already synchronised/debounced level.
- btn_r  in  1  right player button, already synchronised/debounced level.
- start  in  1  start/restart request, level, sampled every clk.
- pos  out  POS_W  current rope position.
- led  out  POS_MAX+1  one-hot of `pos`; led[pos]=1.
- count  out  CNT_W  remaining countdown ticks; 0 outside COUNTDOWN.
- playing  out  1  high in PLAY.
- win_l  out  1  left player won (pos reached 0).
- win_r  out  1  right player won (pos reached POS_MAX).

Behaviour:
- Clocking and reset
  - All state updates on posedge clk.
  - rst asserted: state=IDLE, pos=POS_MAX/2, led=one-hot centre, count=0, playing=0, win_l=win_r=0, pending flags and edge registers cleared.
  - Reset mid-round aborts immediately to these values.
- Edge detect
  - Registered previous levels of btn_l/btn_r.
  - A press is the cycle where level=1 and previous=0.
  - A held button produces one press only.
- Pending flags pend_l/pend_r
  - Set by a press in PLAY.
  - Cleared on every tick in PLAY and on any state change.
  - If a press and a tick occur in the same cycle, the press counts toward that tick's decision.
- FSM
  - IDLE: outputs at centre. start=1 → COUNTDOWN, count=START_TICKS.
  - COUNTDOWN: each tick decrements count. A tick with count=1 → PLAY next cycle, count=0. Presses are ignored (see Optional Feature).
  - PLAY: playing=1. On tick, using the effective pending values:
    - only L pending: pos-1.
    - only R pending: pos+1.
    - both pending or neither: pos unchanged (tie cancels).
    - New pos=0 → WIN, win_l=1. New pos=POS_MAX → WIN, win_r=1.
    - Position updates only on tick; latency is one clk after the tick cycle.
  - WIN: pos, led and winner flag held; buttons ignored. start=1 → COUNTDOWN with pos=centre, win flags cleared, count=START_TICKS.
- Other start handling: start in COUNTDOWN or PLAY is ignored. A held start in WIN restarts only once, because the state leaves WIN.
- Arithmetic: pos never wraps. The transition to WIN happens in the same cycle the bound is reached, so no move is ever attempted beyond 0 or POS_MAX.
- All outputs are registered, or decoded combinationally from registered state only.

Optional Feature:
- Macro FALSE_START_EN.
  - Defined: a press in COUNTDOWN is a false start. The offender loses: → WIN next cycle, opposing win flag set, pos forced to the winner's end (0 for win_l, POS_MAX for win_r). Simultaneous false starts by both players → back to IDLE, pos=centre, no winner.
  - Undefined: countdown presses are discarded with no effect.

Test Plan:
- Reset during PLAY at pos=6 → next clk pos=4, led=9'b000010000, state IDLE, win flags 0, count 0.
- start=1, then 3 ticks → count 3→2→1→0, playing=1 one clk after the third tick; btn_r pressed before each of the next 4 ticks → pos 5,6,7,8, win_r=1, playing=0.
- PLAY at pos=4: btn_l and btn_r pressed in the same tick window → pos stays 4. btn_l held high across 5 ticks → only one move, to pos=3.
- Press btn_l in the same cycle as a tick at pos=1 → pos=0, win_l=1. Further presses and ticks → pos stays 0. start=1 → count=3, pos=4, win_l=0.
- FALSE_START_EN defined: btn_l press at count=2 → win_r=1, pos=8. Both pressed in the same countdown cycle → IDLE, pos=4, no winner.
- FALSE_START_EN undefined: btn_l press at count=2 → no effect; PLAY entered normally with pos=4.
